// File: rtl/mic_pkg.sv
// Shared constants and transmitter FSM encoding for the microphone-array audio path.
// The receiver model imports the same state type so both sides decode identically.
package mic_pkg;

  localparam int I2S_SLOT_W = 32;
  localparam int I2S_DATA_W = 24;

  typedef enum logic [1:0] {
    S_SYNC,
    S_SHIFT,
    S_PAD
  } i2s_tx_state_t;

endpackage

// File: rtl/i2s_slot_shifter.sv
// Parallel-load MSB-first shifter with a sent-bit counter.
// Loading counts the MSB as already sent, because the parent registers it in the load cycle.
module i2s_slot_shifter
  import mic_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_dat,
  input  logic              shift,
  output logic              msb,
  output logic              done
);

  localparam int CNT_W = $clog2(SLOT_W) + 1;
  localparam logic [CNT_W-1:0] BITS = CNT_W'(DATA_W);

  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_dat << 1;
      cnt <= CNT_W'(1);
    end else if (shift) begin
      sr  <= sr << 1;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign msb  = sr[DATA_W-1];
  assign done = (cnt >= BITS);

endmodule

// File: rtl/i2s_mic_tx.sv
// I2S transmitter: MSB lands on o_dat at the LRCK-change posedge (one-bit delay), DATA_W bits then zero pad.
// A one-pair pending buffer holds o_ready low until the next left-slot start; an empty buffer yields a zero frame.
module i2s_mic_tx
  import mic_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  logic              i_BCLK,
  input  logic              i_rst,
  input  logic              i_LRCK,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  output logic              o_ready,
  output logic              o_dat,
  output logic              o_underrun,
  output logic              o_slot_err
);

  logic              lrck_q;
  logic              lrck_seen;
  logic              pend_full;
  logic [DATA_W-1:0] pend_l;
  logic [DATA_W-1:0] pend_r;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] load_dat;
  i2s_tx_state_t     state;

  logic lr_edge;
  logic left_start;
  logic right_start;
  logic slot_start;
  logic accept;
  logic sh_msb;
  logic sh_done;
  logic sh_shift;

  // Rising edges before the first left slot are ignored so a frame never starts mid-pair.
  assign lr_edge     = lrck_seen && (i_LRCK != lrck_q);
  assign left_start  = lr_edge && !i_LRCK;
  assign right_start = lr_edge && i_LRCK && (state != S_SYNC);
  assign slot_start  = left_start || right_start;
  assign accept      = i_valid && !pend_full;
  assign o_ready     = !pend_full;
  assign load_dat    = left_start ? (pend_full ? pend_l : '0) : shadow;
  assign sh_shift    = (state == S_SHIFT) && !slot_start && !sh_done;

  always_ff @(posedge i_BCLK or posedge i_rst) begin
    if (i_rst) begin
      lrck_q    <= 1'b0;
      lrck_seen <= 1'b0;
    end else begin
      lrck_q    <= i_LRCK;
      lrck_seen <= 1'b1;
    end
  end

  // A pair accepted on a left-start edge only fills pending; it goes out next frame.
  always_ff @(posedge i_BCLK or posedge i_rst) begin
    if (i_rst) begin
      pend_full <= 1'b0;
      pend_l    <= '0;
      pend_r    <= '0;
      shadow    <= '0;
    end else begin
      if (accept) begin
        pend_full <= 1'b1;
        pend_l    <= i_left;
        pend_r    <= i_right;
      end else if (left_start) begin
        pend_full <= 1'b0;
      end
      if (left_start) begin
        shadow <= pend_full ? pend_r : '0;
      end
    end
  end

  always_ff @(posedge i_BCLK or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_SYNC;
      o_dat      <= 1'b0;
      o_underrun <= 1'b0;
      o_slot_err <= 1'b0;
    end else begin
      o_underrun <= left_start && !pend_full;
      o_slot_err <= slot_start && (state == S_SHIFT) && !sh_done;
      if (slot_start) begin
        state <= S_SHIFT;
        o_dat <= load_dat[DATA_W-1];
      end else begin
        case (state)
          S_SHIFT: begin
            if (sh_done) begin
              state <= S_PAD;
              o_dat <= 1'b0;
            end else begin
              o_dat <= sh_msb;
            end
          end
          default: o_dat <= 1'b0;
        endcase
      end
    end
  end

  i2s_slot_shifter #(
    .DATA_W(DATA_W),
    .SLOT_W(SLOT_W)
  ) u_shifter (
    .clk     (i_BCLK),
    .rst     (i_rst),
    .load    (slot_start),
    .load_dat(load_dat),
    .shift   (sh_shift),
    .msb     (sh_msb),
    .done    (sh_done)
  );

endmodule

// File: tb/tb_i2s_mic_tx.sv
// Bench for i2s_mic_tx: directed frames plus randomized slot lengths and traffic,
// checked every BCLK against a slot/position-level reference model.
module tb_i2s_mic_tx;

  localparam int DW = 24;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_LRCK;
  logic          i_valid;
  logic [DW-1:0] i_left;
  logic [DW-1:0] i_right;
  logic          o_ready;
  logic          o_dat;
  logic          o_underrun;
  logic          o_slot_err;

  int total = 0;
  int bad   = 0;

  // reference model state: one pending pair, current slot sample and bit position
  logic            m_seen, m_sync, m_prev;
  int              m_pos;
  logic [DW-1:0]   m_cur, m_rsh;
  logic [2*DW-1:0] m_pq[$];
  logic            e_dat, e_rdy, e_ur, e_se;

  always #5 clk = ~clk;

  i2s_mic_tx #(.DATA_W(DW), .SLOT_W(SW)) dut (
    .i_BCLK    (clk),
    .i_rst     (i_rst),
    .i_LRCK    (i_LRCK),
    .i_valid   (i_valid),
    .i_left    (i_left),
    .i_right   (i_right),
    .o_ready   (o_ready),
    .o_dat     (o_dat),
    .o_underrun(o_underrun),
    .o_slot_err(o_slot_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic rst, input logic lr, input logic v,
                       input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic            ready_b, edg;
    logic [2*DW-1:0] pr;
    e_ur = 1'b0;
    e_se = 1'b0;
    if (rst) begin
      m_seen = 1'b0; m_sync = 1'b0; m_prev = 1'b0; m_pos = 0;
      m_cur = '0; m_rsh = '0;
      m_pq.delete();
      e_dat = 1'b0; e_rdy = 1'b1;
      return;
    end
    ready_b = (m_pq.size() == 0);
    edg     = m_seen && (lr != m_prev);
    if (edg && (!lr || m_sync)) begin
      if (m_sync && (m_pos + 1 < DW)) e_se = 1'b1;
      if (!lr) begin
        if (m_pq.size() > 0) begin
          pr    = m_pq.pop_front();
          m_cur = pr[2*DW-1:DW];
          m_rsh = pr[DW-1:0];
        end else begin
          m_cur = '0; m_rsh = '0; e_ur = 1'b1;
        end
        m_sync = 1'b1;
      end else begin
        m_cur = m_rsh;
      end
      m_pos = 0;
    end else if (m_sync && m_pos < 1000) begin
      m_pos++;
    end
    if (v && ready_b) m_pq.push_back({l, r});
    m_seen = 1'b1;
    m_prev = lr;
    e_dat  = 1'b0;
    if (m_sync && m_pos < DW) e_dat = m_cur[DW-1-m_pos];
    e_rdy = (m_pq.size() == 0);
  endtask

  task automatic step(input logic rst, input logic lr, input logic v,
                      input logic [DW-1:0] l, input logic [DW-1:0] r);
    i_rst = rst; i_LRCK = lr; i_valid = v; i_left = l; i_right = r;
    @(posedge clk);
    model(rst, lr, v, l, r);
    #1;
    chk("dat", 64'(o_dat), 64'(e_dat));
    chk("ready", 64'(o_ready), 64'(e_rdy));
    chk("underrun", 64'(o_underrun), 64'(e_ur));
    chk("slot_err", 64'(o_slot_err), 64'(e_se));
  endtask

  // vmode 0: idle, 1: offer l/r until accepted, 2: random traffic
  task automatic slot(input logic lr, input int len, input int vmode,
                      input logic [DW-1:0] l, input logic [DW-1:0] r,
                      output logic [63:0] w, output int nur, output int nse);
    logic          held, v;
    logic [DW-1:0] dl, dr;
    held = (vmode == 1);
    w = '0; nur = 0; nse = 0;
    for (int i = 0; i < len; i++) begin
      if (vmode == 2) begin
        v  = ($urandom_range(0, 2) == 0);
        dl = DW'($urandom);
        dr = DW'($urandom);
      end else begin
        v = held; dl = l; dr = r;
        if (held && o_ready) held = 1'b0;
      end
      step(1'b0, lr, v, dl, dr);
      w = {w[62:0], o_dat};
      if (o_underrun) nur++;
      if (o_slot_err) nse++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [63:0]   w;
    int            nur, nse, ll, lrn;
    logic [DW-1:0] a_l, a_r, p1_l, p1_r, p2_l, p2_r, p3_l, p3_r, p4_l, p4_r, p5_l, p5_r, p6_l, p6_r;
    a_l  = 24'hA50F3C; a_r  = 24'h800001;
    p1_l = 24'h123456; p1_r = 24'h654321;
    p2_l = 24'hFEDCBA; p2_r = 24'h0F0F0F;
    p3_l = 24'h5A5A5A; p3_r = 24'hC3C3C3;
    p4_l = 24'h8F00F1; p4_r = 24'h7E81E7;
    p5_l = 24'hFFFFFF; p5_r = 24'h000FFF;
    p6_l = 24'h111111; p6_r = 24'h222222;

    step(1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    chk("rst_dat", 64'(o_dat), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_underrun", 64'(o_underrun), 64'd0);
    chk("rst_slot_err", 64'(o_slot_err), 64'd0);

    // first pair, then a full frame
    slot(1'b1, 4, 1, a_l, a_r, w, nur, nse);
    chk("load_ready", 64'(o_ready), 64'd0);
    slot(1'b0, SW, 0, '0, '0, w, nur, nse);
    chk("left_word", w, 64'({a_l, 8'h00}));
    chk("left_no_underrun", 64'(nur), 64'd0);
    slot(1'b1, SW, 0, '0, '0, w, nur, nse);
    chk("right_word", w, 64'({a_r, 8'h00}));

    // underrun frame; P1 then held P2 offered in its right slot
    slot(1'b0, SW, 0, '0, '0, w, nur, nse);
    chk("underrun_left_zero", w, 64'd0);
    chk("underrun_count", 64'(nur), 64'd1);
    slot(1'b1, 16, 0, '0, '0, w, nur, nse);
    chk("underrun_right_zero", w, 64'd0);
    slot(1'b1, 1, 1, p1_l, p1_r, w, nur, nse);
    slot(1'b1, 15, 1, p2_l, p2_r, w, nur, nse);
    chk("p2_blocked", 64'(o_ready), 64'd0);
    slot(1'b0, SW, 1, p2_l, p2_r, w, nur, nse);
    chk("p1_left", w, 64'({p1_l, 8'h00}));
    slot(1'b1, SW, 0, '0, '0, w, nur, nse);
    chk("p1_right", w, 64'({p1_r, 8'h00}));
    slot(1'b0, SW, 0, '0, '0, w, nur, nse);
    chk("p2_left", w, 64'({p2_l, 8'h00}));
    slot(1'b1, SW, 0, '0, '0, w, nur, nse);
    chk("p2_right", w, 64'({p2_r, 8'h00}));

    // acceptance on the left-edge cycle itself: no bypass
    slot(1'b0, SW, 1, p3_l, p3_r, w, nur, nse);
    chk("edge_accept_zero", w, 64'd0);
    chk("edge_accept_underrun", 64'(nur), 64'd1);
    slot(1'b1, SW, 0, '0, '0, w, nur, nse);
    slot(1'b0, SW, 0, '0, '0, w, nur, nse);
    chk("p3_left", w, 64'({p3_l, 8'h00}));
    slot(1'b1, SW, 1, p4_l, p4_r, w, nur, nse);
    chk("p3_right", w, 64'({p3_r, 8'h00}));

    // short left slot of 16 bits
    slot(1'b0, 16, 0, '0, '0, w, nur, nse);
    chk("short_left", w, 64'(p4_l[23:8]));
    slot(1'b1, SW, 1, p5_l, p5_r, w, nur, nse);
    chk("short_err_count", 64'(nse), 64'd1);
    chk("short_next_right", w, 64'({p4_r, 8'h00}));

    // reset at bit 10 of a left slot
    slot(1'b0, 11, 1, p6_l, p6_r, w, nur, nse);
    chk("pre_rst_dat", 64'(o_dat), 64'd1);
    chk("pre_rst_ready", 64'(o_ready), 64'd0);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_dat", 64'(o_dat), 64'd0);
    chk("async_rst_ready", 64'(o_ready), 64'd1);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    slot(1'b0, 2, 0, '0, '0, w, nur, nse);
    slot(1'b1, SW, 0, '0, '0, w, nur, nse);
    chk("post_rst_rise_zero", w, 64'd0);
    chk("post_rst_rise_no_err", 64'(nur + nse), 64'd0);
    slot(1'b0, SW, 0, '0, '0, w, nur, nse);
    chk("post_rst_discarded", w, 64'd0);
    chk("post_rst_underrun", 64'(nur), 64'd1);
    slot(1'b1, SW, 0, '0, '0, w, nur, nse);

    // random slot lengths (some short, some long) with random traffic
    repeat (24) begin
      ll  = ($urandom_range(0, 3) == 0) ? $urandom_range(4, DW - 1) : $urandom_range(DW, SW + 4);
      lrn = ($urandom_range(0, 3) == 0) ? $urandom_range(4, DW - 1) : $urandom_range(DW, SW + 4);
      slot(1'b0, ll, 2, '0, '0, w, nur, nse);
      slot(1'b1, lrn, 2, '0, '0, w, nur, nse);
    end
    slot(1'b0, SW, 0, '0, '0, w, nur, nse);
    slot(1'b1, SW, 0, '0, '0, w, nur, nse);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
